// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bundle for the forwarding / load-use hazard controller.
// The master is the decode stage; the slave is fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);

  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;

  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              id_byp_rs1_o;
  logic              id_byp_rs2_o;

  modport master (
    output hold_i, flush_i, id_valid_i, id_rs1_i, id_rs2_i,
           id_use_rs1_i, id_use_rs2_i, id_rd_i, id_reg_write_i, id_mem_read_i,
    input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o, id_byp_rs1_o, id_byp_rs2_o
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_rs1_i, id_rs2_i,
           id_use_rs1_i, id_use_rs2_i, id_rd_i, id_reg_write_i, id_mem_read_i,
    output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o, id_byp_rs1_o, id_byp_rs2_o
  );

endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage RV32 pipeline.
// Optional ID read-during-write bypass from the WB slot: define FWD_WB_BYPASS_EN.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  fwd_hazard_ctrl_if.slave   bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
  } wr_slot_t;

  ex_slot_t         ex_q, ex_d;
  wr_slot_t         mem_q, wb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  logic [1:0]       fwd_a, fwd_b;

  // A slot supplies r only if it really writes a non-x0 destination equal to r.
  function automatic logic match(input wr_slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wr && (s.rd != '0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_AW-1:0] r,
                                         input wr_slot_t mem_s, input wr_slot_t wb_s);
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_r && match(mem_s, r))     sel = SEL_MEM;
    else if (use_r && match(wb_s, r)) sel = SEL_WB;
    return sel;
  endfunction

  // Load in EX whose rd is read by the instruction in ID; a flushed ID needs no stall.
  always_comb begin
    load_use = 1'b0;
    if (bus.id_valid_i && ex_q.valid && ex_q.ld && (ex_q.rd != '0) && !bus.flush_i) begin
      load_use = (bus.id_use_rs1_i && (bus.id_rs1_i == ex_q.rd)) ||
                 (bus.id_use_rs2_i && (bus.id_rs2_i == ex_q.rd));
    end
  end

  always_comb begin
    fwd_a = SEL_RF;
    fwd_b = SEL_RF;
    if (ex_q.valid) begin
      fwd_a = fwd_sel(ex_q.use1, ex_q.rs1, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.use2, ex_q.rs2, mem_q, wb_q);
    end
  end

  // Next EX slot: bubble on flush or load-use, otherwise the ID instruction.
  always_comb begin
    ex_d = '0;
    if (!bus.flush_i && !load_use) begin
      ex_d.valid = bus.id_valid_i;
      ex_d.rs1   = bus.id_rs1_i;
      ex_d.rs2   = bus.id_rs2_i;
      ex_d.use1  = bus.id_use_rs1_i;
      ex_d.use2  = bus.id_use_rs2_i;
      ex_d.rd    = bus.id_rd_i;
      ex_d.wr    = bus.id_reg_write_i;
      ex_d.ld    = bus.id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!bus.hold_i) begin
      wb_q  <= mem_q;
      mem_q <= wr_slot_t'{valid: ex_q.valid, rd: ex_q.rd, wr: ex_q.wr};
      ex_q  <= ex_d;
      if (load_use && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_a_o     = fwd_a;
  assign bus.fwd_b_o     = fwd_b;
  assign bus.stall_o     = load_use;
  assign bus.stall_cnt_o = cnt_q;

`ifdef FWD_WB_BYPASS_EN
  assign bus.id_byp_rs1_o = bus.id_use_rs1_i && match(wb_q, bus.id_rs1_i);
  assign bus.id_byp_rs2_o = bus.id_use_rs2_i && match(wb_q, bus.id_rs2_i);
`else
  assign bus.id_byp_rs1_o = 1'b0;
  assign bus.id_byp_rs2_o = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: per-cycle expectations are queued when
// ID stimulus is driven and compared on the following falling edge.
module tb_fwd_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 2;
`ifdef FWD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  typedef struct {
    string            tag;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             st;
    logic [CNT_W-1:0] cnt;
    logic             cb;
    logic             by;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CNT_W-1:0] cnt_exp  = '0;
  logic             clk      = 1'b0;
  logic             rst_n;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic instr_t mk(input logic [4:0] rd, input logic wr, input logic ld,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
    return instr_t'{v: 1'b1, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, wr: wr, ld: ld};
  endfunction

  // Drive one ID cycle, queue what the outputs must show during it, then advance.
  task automatic step(input string tag, input instr_t ins, input logic hold, input logic flush,
                      input logic rst, input logic chk, input logic [1:0] fa, input logic [1:0] fb,
                      input logic st, input logic cb, input logic by);
    exp_t e;
    rst_n              = rst;
    bus.hold_i         = hold;
    bus.flush_i        = flush;
    bus.id_valid_i     = ins.v;
    bus.id_rs1_i       = ins.rs1;
    bus.id_rs2_i       = ins.rs2;
    bus.id_use_rs1_i   = ins.u1;
    bus.id_use_rs2_i   = ins.u2;
    bus.id_rd_i        = ins.rd;
    bus.id_reg_write_i = ins.wr;
    bus.id_mem_read_i  = ins.ld;
    if (chk) begin
      e.tag = tag; e.fa = fa; e.fb = fb; e.st = st;
      e.cnt = cnt_exp; e.cb = cb; e.by = by;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!rst) cnt_exp = '0;
    else if (st && !hold && cnt_exp != '1) cnt_exp = cnt_exp + CNT_W'(1);
    #1;
  endtask

  task automatic cyc(input string tag, input instr_t ins, input logic [1:0] fa,
                     input logic [1:0] fb, input logic st);
    step(tag, ins, 1'b0, 1'b0, 1'b1, 1'b1, fa, fb, st, 1'b0, 1'b0);
  endtask

  task automatic hcyc(input string tag, input instr_t ins, input logic [1:0] fa,
                      input logic [1:0] fb, input logic st);
    step(tag, ins, 1'b1, 1'b0, 1'b1, 1'b1, fa, fb, st, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".fwd_a"}, 32'(bus.fwd_a_o), 32'(mon_e.fa));
      check({mon_e.tag, ".fwd_b"}, 32'(bus.fwd_b_o), 32'(mon_e.fb));
      check({mon_e.tag, ".stall"}, 32'(bus.stall_o), 32'(mon_e.st));
      check({mon_e.tag, ".cnt"},   32'(bus.stall_cnt_o), 32'(mon_e.cnt));
      if (mon_e.cb) begin
        check({mon_e.tag, ".byp1"}, 32'(bus.id_byp_rs1_o), 32'(mon_e.by));
        check({mon_e.tag, ".byp2"}, 32'(bus.id_byp_rs2_o), 32'(mon_e.by));
      end
    end
  end

  initial begin
    instr_t nop, lw7, add7;
    nop  = '0;
    lw7  = mk(5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
    add7 = mk(5'd10, 1'b1, 1'b0, 5'd2, 1'b1, 5'd7, 1'b1);
    rst_n = 1'b0;
    bus.hold_i = 1'b0; bus.flush_i = 1'b0; bus.id_valid_i = 1'b0;
    bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_use_rs1_i = 1'b0; bus.id_use_rs2_i = 1'b0;
    bus.id_rd_i = '0; bus.id_reg_write_i = 1'b0; bus.id_mem_read_i = 1'b0;
    @(posedge clk); #1;
    step("rst0", lw7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step("rst1", lw7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step("reset", mk(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, 1'b1, 1'b1,
         2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

    // EX/MEM forward to operand A
    cyc("exmem_w",  mk(5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 2'b00, 2'b00, 0);
    cyc("exmem_r",  mk(5'd6, 1, 0, 5'd5, 1, 5'd3, 1), 2'b00, 2'b00, 0);
    cyc("exmem_ex", nop, 2'b10, 2'b00, 0);
    cyc("exmem_gap", nop, 2'b00, 2'b00, 0);

    // Two writers of x5: youngest (EX/MEM) wins; with a gap only MEM/WB remains
    cyc("pri_w1", mk(5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 2'b00, 2'b00, 0);
    cyc("pri_w2", mk(5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 2'b00, 2'b00, 0);
    cyc("pri_r",  mk(5'd8, 1, 0, 5'd4, 1, 5'd5, 1), 2'b00, 2'b00, 0);
    cyc("pri_ex", nop, 2'b00, 2'b10, 0);
    cyc("gap_w",  mk(5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 2'b00, 2'b00, 0);
    cyc("gap_n",  nop, 2'b00, 2'b00, 0);
    cyc("gap_r",  mk(5'd8, 1, 0, 5'd5, 0, 5'd5, 1), 2'b00, 2'b00, 0);
    cyc("gap_ex", nop, 2'b00, 2'b01, 0);

    // Load-use: one stall, bubble, then MEM/WB forward
    cyc("lu_lw",    lw7,  2'b00, 2'b00, 0);
    cyc("lu_stall", add7, 2'b00, 2'b00, 1);
    cyc("lu_bub",   add7, 2'b00, 2'b00, 0);
    cyc("lu_ex",    nop,  2'b00, 2'b01, 0);
    cyc("lu_gap",   nop,  2'b00, 2'b00, 0);

    // x0 never forwards or stalls
    cyc("x0_w",   mk(5'd0, 1, 0, 5'd1, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    cyc("x0_r",   mk(5'd11, 1, 0, 5'd0, 1, 5'd0, 1), 2'b00, 2'b00, 0);
    cyc("x0_ex",  nop, 2'b00, 2'b00, 0);
    cyc("x0_lw",  mk(5'd0, 1, 1, 5'd1, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    cyc("x0_lr",  mk(5'd12, 1, 0, 5'd0, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    cyc("x0_lex", nop, 2'b00, 2'b00, 0);

    // Flush squashes the dependent: no stall, EX empty afterwards
    cyc("fl_lw", mk(5'd3, 1, 1, 5'd1, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    step("fl_dep", mk(5'd13, 1, 0, 5'd3, 1, 5'd0, 0), 1'b0, 1'b1, 1'b1, 1'b1,
         2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("fl_ex",  nop, 2'b00, 2'b00, 0);
    cyc("fl_gap", nop, 2'b00, 2'b00, 0);

    // Hold across a pending stall: counter and slots frozen
    cyc("h_lw", lw7, 2'b00, 2'b00, 0);
    for (int i = 0; i < 3; i++)
      hcyc($sformatf("h_stall%0d", i), mk(5'd14, 1, 0, 5'd7, 1, 5'd0, 0), 2'b00, 2'b00, 1);
    cyc("h_stall", mk(5'd14, 1, 0, 5'd7, 1, 5'd0, 0), 2'b00, 2'b00, 1);
    cyc("h_bub",   mk(5'd14, 1, 0, 5'd7, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    cyc("h_ex",    nop, 2'b01, 2'b00, 0);

    // Hold while a forward is active
    cyc("hf_w", mk(5'd5, 1, 0, 5'd1, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    cyc("hf_r", mk(5'd6, 1, 0, 5'd5, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    for (int i = 0; i < 3; i++) hcyc($sformatf("hf_hold%0d", i), nop, 2'b10, 2'b00, 0);
    cyc("hf_ex",  nop, 2'b10, 2'b00, 0);
    cyc("hf_gap", nop, 2'b00, 2'b00, 0);

    // Three more load-use pairs drive the 2-bit counter into saturation
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("sat%0d_lw", k),  lw7,  2'b00, 2'b00, 0);
      cyc($sformatf("sat%0d_st", k),  add7, 2'b00, 2'b00, 1);
      cyc($sformatf("sat%0d_bub", k), add7, 2'b00, 2'b00, 0);
      cyc($sformatf("sat%0d_ex", k),  nop,  2'b00, 2'b01, 0);
    end

    // WB-slot bypass to an ID read, exactly three cycles after issue
    cyc("byp_w", mk(5'd9, 1, 0, 5'd1, 1, 5'd0, 0), 2'b00, 2'b00, 0);
    cyc("byp_n1", nop, 2'b00, 2'b00, 0);
    cyc("byp_n2", nop, 2'b00, 2'b00, 0);
    step("byp_rd", mk(5'd15, 1, 0, 5'd9, 1, 5'd9, 1), 1'b0, 1'b0, 1'b1, 1'b1,
         2'b00, 2'b00, 1'b0, 1'b1, BYP);
    step("byp_ex", nop, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a stall leaves nothing pending
    cyc("mr_lw", lw7, 2'b00, 2'b00, 0);
    step("mr_rst", add7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("mr_id", add7, 2'b00, 2'b00, 0);
    cyc("mr_ex", nop,  2'b00, 2'b00, 0);
    cyc("mr_end", nop, 2'b00, 2'b00, 0);

    @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
